flag_ctx_restore: RTL and testbench
===================================

Name: flag_ctx_restore

Overview:
- Owns the CPU C/Z flags, the interrupt-enable flag I and a shadow stack of C/Z.
- On interrupt entry it pushes C/Z and clears I. On RETID/RETIE it pops the shadow back into C/Z and sets I.
- Sits between the ALU/control unit and the interrupt line.
- Default DEPTH=1 gives single-level shadow behaviour.

Parameters:
- DEPTH, 1, number of C/Z shadow entries (nesting levels); legal 1..8.
- CW, 4, width of SHAD_CNT; must satisfy 2**CW > DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- ALU_C  in  1  carry result from ALU.
- ALU_Z  in  1  zero result from ALU.
- FLG_LD  in  1  load C and Z from ALU_C/ALU_Z.
- FLG_C_SET  in  1  set C (SEC).
- FLG_C_CLR  in  1  clear C (CLC).
- SEI  in  1  set I.
- CLI  in  1  clear I.
- INTR  in  1  external interrupt request, already synchronised to clk.
- INSTR_BND  in  1  control unit is at an instruction boundary and may take an interrupt.
- RETI_EN  in  1  execute return-from-interrupt this cycle.
- RETI_IE  in  1  with RETI_EN: 1 = RETIE (I<=1), 0 = RETID (I<=0).
- C_FLG  out  1  current carry flag.
- Z_FLG  out  1  current zero flag.
- I_FLG  out  1  current interrupt-enable flag.
- INT_PEND  out  1  latched pending request.
- INT_TAKEN  out  1  one-cycle pulse; control unit vectors to ISR.
- SHAD_CNT  out  CW  number of occupied shadow entries.
- STK_OVF  out  1  sticky: push attempted with stack full.
- STK_UNF  out  1  sticky: pop attempted with stack empty.

Behaviour:
- Reset (RST_N=0 at clk edge):
  - C, Z, I, INT_PEND, INT_TAKEN, STK_OVF, STK_UNF = 0; SHAD_CNT = 0.
  - Edge-detect register = 0; FSM = RUN; shadow contents don't-care.
  - Reset overrides every other input in that cycle, including mid-ACK.
- INT_PEND:
  - Set on the rising edge of INTR (INTR=1 and previous sample 0).
  - Held until taken; unaffected by CLI.
  - A new edge while already pending is absorbed (no count).
- FSM has two states: RUN and ACK.
- RUN, take condition is INT_PEND & I & INSTR_BND & !RETI_EN. When true, at the edge:
  - Push {C,Z} to shadow[SHAD_CNT] and increment SHAD_CNT.
  - If SHAD_CNT==DEPTH: do not push, leave the count unchanged, set STK_OVF; the interrupt is still taken.
  - I<=0, INT_PEND<=0, next state ACK.
  - C/Z keep their current values; FLG_LD, FLG_C_SET and FLG_C_CLR are ignored that cycle.
  - An INTR rising edge in that same cycle re-sets INT_PEND.
- ACK:
  - INT_TAKEN=1 for exactly this one cycle; next state RUN.
  - No take is possible in ACK.
  - RETI_EN, SEI and CLI are ignored in ACK.
  - Flag updates proceed normally.
- RUN, RETI_EN=1:
  - If SHAD_CNT>0: decrement SHAD_CNT and load {C,Z} <= shadow[SHAD_CNT-1].
  - If SHAD_CNT==0: C/Z are unchanged and STK_UNF is set.
  - I<=RETI_IE in both cases.
  - FLG_LD, FLG_C_SET, FLG_C_CLR, SEI and CLI are ignored that cycle.
  - RETI wins over a simultaneous take; the pending request is retained. After RETIE it is taken at the next qualifying boundary, no earlier than the following cycle.
- Normal flag updates (RUN without take/RETI, or ACK):
  - C priority: FLG_C_CLR > FLG_C_SET > FLG_LD (ALU_C) > hold.
  - Z: FLG_LD (ALU_Z) > hold.
  - I: CLI > SEI > hold.
- Flag latency:
  - All outputs are registered.
  - A flag change is visible the cycle after the controlling edge.
  - C_FLG/Z_FLG/I_FLG/INT_PEND/SHAD_CNT/STK_* come straight from registers.
- STK_OVF/STK_UNF clear only on reset.
- SHAD_CNT never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset: drive random inputs with RST_N=0 for 3 cycles, release -> all outputs 0, FSM in RUN, no INT_TAKEN.
- Basic entry/return, DEPTH=1:
  - Setup: FLG_LD with ALU_C=1, ALU_Z=0, then SEI, then INTR pulse, then INSTR_BND.
  - Entry -> INT_TAKEN pulses one cycle; I=0; SHAD_CNT=1.
  - In the ISR, FLG_LD with ALU_C=0, ALU_Z=1 -> C=0, Z=1.
  - RETI_EN with RETI_IE=1 -> C=1, Z=0, I=1, SHAD_CNT=0.
- Pending with I=0: INTR pulse while I=0 over 5 boundaries -> INT_PEND=1, no INT_TAKEN; SEI -> taken at the next INSTR_BND; INT_PEND=0.
- Overflow/underflow, DEPTH=1:
  - Inside the ISR, SEI then a second INTR+INSTR_BND -> taken, SHAD_CNT stays 1, STK_OVF=1.
  - Two RETIDs -> the first restores the entry flags; the second sets STK_UNF=1 with C/Z unchanged and I=0.
- Simultaneous events:
  - RETI_EN with a qualifying take in the same cycle -> RETI executes, INT_PEND stays 1, take occurs one cycle later.
  - FLG_C_SET+FLG_C_CLR+FLG_LD(ALU_C=1) together -> C=0.
- Nesting, DEPTH=2:
  - Pushes {1,0} then {0,1} -> SHAD_CNT=2.
  - Pops restore {0,1} then {1,0} in LIFO order.

Source files
------------

// File: rtl/flag_ctx_restore.sv
// Purpose: owns C/Z/I flags, latches interrupt requests, and keeps a LIFO shadow of C/Z across ISR nesting.
// Latency: every output is registered; a flag, pending or count change is visible the cycle after its edge.
// Backpressure: none; a push into a full shadow or a pop from an empty one sets a sticky error and carries on.
module flag_ctx_restore #(
  parameter int DEPTH = 1,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          RST_N,
  input  logic          ALU_C,
  input  logic          ALU_Z,
  input  logic          FLG_LD,
  input  logic          FLG_C_SET,
  input  logic          FLG_C_CLR,
  input  logic          SEI,
  input  logic          CLI,
  input  logic          INTR,
  input  logic          INSTR_BND,
  input  logic          RETI_EN,
  input  logic          RETI_IE,
  output logic          C_FLG,
  output logic          Z_FLG,
  output logic          I_FLG,
  output logic          INT_PEND,
  output logic          INT_TAKEN,
  output logic [CW-1:0] SHAD_CNT,
  output logic          STK_OVF,
  output logic          STK_UNF
);

  typedef enum logic {RUN = 1'b0, ACK = 1'b1} state_t;

  state_t        state, state_n;
  logic          c_q, z_q, i_q, pend_q, taken_q, ovf_q, unf_q, intr_q;
  logic          c_n, z_n, i_n, pend_n, taken_n, ovf_n, unf_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    shad [DEPTH];
  logic [1:0]    pop_val;
  logic          push;
  logic          c_upd, z_upd;

  logic rise, take, reti, full, empty;

  // Request qualification; RETI in the same cycle defers the take by at least one cycle.
  assign rise  = INTR & ~intr_q;
  assign take  = (state == RUN) & pend_q & i_q & INSTR_BND & ~RETI_EN;
  assign reti  = (state == RUN) & RETI_EN;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Normal flag update: CLC beats SEC beats ALU load for C; Z only follows the ALU load.
  always_comb begin
    c_upd = c_q;
    z_upd = z_q;
    if (FLG_C_CLR)      c_upd = 1'b0;
    else if (FLG_C_SET) c_upd = 1'b1;
    else if (FLG_LD)    c_upd = ALU_C;
    if (FLG_LD)         z_upd = ALU_Z;
  end

  // Top-of-shadow read; an empty stack never matches an index so the value is unused.
  always_comb begin
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == cnt_q - CW'(1)) pop_val = shad[i];
    end
  end

  // Next-state and flag decisions for the RUN/ACK sequencer.
  always_comb begin
    state_n = state;
    c_n     = c_q;
    z_n     = z_q;
    i_n     = i_q;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
    unf_n   = unf_q;
    push    = 1'b0;
    taken_n = take;
    // A rising edge in the take cycle re-arms the request that is being consumed.
    pend_n  = rise | (pend_q & ~take);
    case (state)
      RUN: begin
        if (take) begin
          state_n = ACK;
          i_n     = 1'b0;
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            push  = 1'b1;
            cnt_n = cnt_q + CW'(1);
          end
        end else if (reti) begin
          i_n = RETI_IE;
          if (empty) begin
            unf_n = 1'b1;
          end else begin
            cnt_n      = cnt_q - CW'(1);
            {c_n, z_n} = pop_val;
          end
        end else begin
          c_n = c_upd;
          z_n = z_upd;
          if (CLI)      i_n = 1'b0;
          else if (SEI) i_n = 1'b1;
        end
      end
      ACK: begin
        // Vector cycle: ALU flags still update, but I and RETI are frozen.
        state_n = RUN;
        c_n     = c_upd;
        z_n     = z_upd;
      end
      default: state_n = RUN;
    endcase
  end

  // State and flag registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state   <= RUN;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      i_q     <= 1'b0;
      pend_q  <= 1'b0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      intr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      c_q     <= c_n;
      z_q     <= z_n;
      i_q     <= i_n;
      pend_q  <= pend_n;
      taken_q <= taken_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
      intr_q  <= INTR;
      cnt_q   <= cnt_n;
    end
  end

  // Shadow storage holds no reset value; only slots below the count are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (RST_N && push && (CW'(i) == cnt_q)) shad[i] <= {c_q, z_q};
    end
  end

  assign C_FLG     = c_q;
  assign Z_FLG     = z_q;
  assign I_FLG     = i_q;
  assign INT_PEND  = pend_q;
  assign INT_TAKEN = taken_q;
  assign SHAD_CNT  = cnt_q;
  assign STK_OVF   = ovf_q;
  assign STK_UNF   = unf_q;

endmodule

// File: tb/tb_flag_ctx_restore.sv
// Bench for flag_ctx_restore: single-level instance for entry/return/pending/overflow cases,
// two-level instance for LIFO nesting. Both share one input stream.
module tb_flag_ctx_restore;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, alu_c, alu_z, flg_ld, c_set, c_clr, sei, cli, intr, bnd, reti_en, reti_ie;

  logic       c1, z1, i1, p1, t1, o1, u1;
  logic [3:0] n1;
  logic       c2, z2, i2, p2, t2, o2, u2;
  logic [3:0] n2;

  flag_ctx_restore #(.DEPTH(1), .CW(4)) dut1 (
    .clk(clk), .RST_N(rst_n), .ALU_C(alu_c), .ALU_Z(alu_z), .FLG_LD(flg_ld),
    .FLG_C_SET(c_set), .FLG_C_CLR(c_clr), .SEI(sei), .CLI(cli), .INTR(intr),
    .INSTR_BND(bnd), .RETI_EN(reti_en), .RETI_IE(reti_ie),
    .C_FLG(c1), .Z_FLG(z1), .I_FLG(i1), .INT_PEND(p1), .INT_TAKEN(t1),
    .SHAD_CNT(n1), .STK_OVF(o1), .STK_UNF(u1)
  );

  flag_ctx_restore #(.DEPTH(2), .CW(4)) dut2 (
    .clk(clk), .RST_N(rst_n), .ALU_C(alu_c), .ALU_Z(alu_z), .FLG_LD(flg_ld),
    .FLG_C_SET(c_set), .FLG_C_CLR(c_clr), .SEI(sei), .CLI(cli), .INTR(intr),
    .INSTR_BND(bnd), .RETI_EN(reti_en), .RETI_IE(reti_ie),
    .C_FLG(c2), .Z_FLG(z2), .I_FLG(i2), .INT_PEND(p2), .INT_TAKEN(t2),
    .SHAD_CNT(n2), .STK_OVF(o2), .STK_UNF(u2)
  );

  // in  = {rst_n, alu_c,alu_z, ld,c_set,c_clr, sei,cli, intr,bnd, reti_en,reti_ie}
  // exp = {c,z,i,pend,taken, cnt[3:0], ovf,unf}
  typedef struct {
    logic [11:0] in;
    logic [10:0] exp;
    bit          sel;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input bit sel, input logic [11:0] in,
                              input logic [4:0] f, input logic [3:0] cnt, input logic [1:0] ou);
    vec_t v;
    v.in  = in;
    v.exp = {f, cnt, ou};
    v.sel = sel;
    return v;
  endfunction

  task automatic drive(input logic [11:0] v);
    {rst_n, alu_c, alu_z, flg_ld, c_set, c_clr, sei, cli, intr, bnd, reti_en, reti_ie} = v;
  endtask

  function automatic logic [10:0] actual(input bit sel);
    if (sel) return {c2, z2, i2, p2, t2, n2, o2, u2};
    return {c1, z1, i1, p1, t1, n1, o1, u1};
  endfunction

  task automatic check(input string name, input bit sel, input logic [10:0] exp);
    logic [10:0] a;
    a = actual(sel);
    n_run++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got c z i p t cnt o u = %b, required %b", name, sel ? 2 : 1, a, exp);
    end
  endtask

  initial begin
    // DEPTH=1: basic entry / ISR flag change / RETIE
    tbl.push_back(mk(0, 12'b1_00_000_00_00_00, 5'b00000, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_10_100_00_00_00, 5'b10000, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_10_00_00, 5'b10100, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_10_00, 5'b10110, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b10001, 4'd1, 2'b00));
    tbl.push_back(mk(0, 12'b1_01_100_00_00_00, 5'b01000, 4'd1, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_11, 5'b10100, 4'd0, 2'b00));
    // pending held with I=0 over five boundaries, CLI does not drop it
    tbl.push_back(mk(0, 12'b1_00_000_01_00_00, 5'b10000, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_11_00, 5'b10010, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b10010, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b10010, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_01_01_00, 5'b10010, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b10010, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_10_00_00, 5'b10110, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b10001, 4'd1, 2'b00));
    // ACK cycle ignores SEI and RETI
    tbl.push_back(mk(0, 12'b1_00_000_10_00_11, 5'b10000, 4'd1, 2'b00));
    // nested take with full shadow -> overflow, count stays 1
    tbl.push_back(mk(0, 12'b1_00_000_10_00_00, 5'b10100, 4'd1, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_10_00, 5'b10110, 4'd1, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b10001, 4'd1, 2'b10));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_00, 5'b10000, 4'd1, 2'b10));
    // two RETIDs: restore, then underflow with C/Z unchanged
    tbl.push_back(mk(0, 12'b1_01_100_00_00_00, 5'b01000, 4'd1, 2'b10));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_10, 5'b10000, 4'd0, 2'b10));
    tbl.push_back(mk(0, 12'b1_01_100_00_00_00, 5'b01000, 4'd0, 2'b10));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_10, 5'b01000, 4'd0, 2'b11));
    // C priority: CLR beats SET and LD; then SET alone
    tbl.push_back(mk(0, 12'b1_00_000_10_00_00, 5'b01100, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_11_111_00_10_00, 5'b01110, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_010_00_00_00, 5'b11110, 4'd0, 2'b11));
    // RETI wins over a qualifying take; take follows next cycle
    tbl.push_back(mk(0, 12'b1_00_000_00_01_11, 5'b11110, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b11001, 4'd1, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_001_00_01_00, 5'b01000, 4'd1, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_10, 5'b11000, 4'd0, 2'b11));
    // INTR edge in the take cycle re-arms pending; flag ops ignored on take
    tbl.push_back(mk(0, 12'b1_00_000_10_00_00, 5'b11100, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_10_00, 5'b11110, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_00, 5'b11110, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_001_00_11_00, 5'b11011, 4'd1, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_10_00, 5'b11010, 4'd1, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_11, 5'b11110, 4'd0, 2'b11));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b11001, 4'd1, 2'b11));
    // reset in the middle of ACK clears everything including sticky bits
    tbl.push_back(mk(0, 12'b0_11_100_10_01_00, 5'b00000, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_00_00, 5'b00000, 4'd0, 2'b00));
    tbl.push_back(mk(0, 12'b1_00_000_00_01_00, 5'b00000, 4'd0, 2'b00));
    // DEPTH=2 nesting: push {1,0} then {0,1}, pop LIFO, then underflow
    tbl.push_back(mk(1, 12'b1_10_100_10_00_00, 5'b10100, 4'd0, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_10_00, 5'b10110, 4'd0, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_01_00, 5'b10001, 4'd1, 2'b00));
    tbl.push_back(mk(1, 12'b1_01_100_00_00_00, 5'b01000, 4'd1, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_10_00_00, 5'b01100, 4'd1, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_10_00, 5'b01110, 4'd1, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_01_00, 5'b01001, 4'd2, 2'b00));
    tbl.push_back(mk(1, 12'b1_11_100_00_00_00, 5'b11000, 4'd2, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_00_10, 5'b01000, 4'd1, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_00_11, 5'b10100, 4'd0, 2'b00));
    tbl.push_back(mk(1, 12'b1_00_000_00_00_10, 5'b10000, 4'd0, 2'b01));

    // Reset held for three cycles under random inputs
    for (int k = 0; k < 3; k++) begin
      drive({1'b0, 11'($urandom)});
      @(posedge clk);
      #1;
    end
    check("reset_dut1", 1'b0, 11'd0);
    check("reset_dut2", 1'b1, 11'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].in);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), tbl[k].sel, tbl[k].exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
